traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
- Sequences the intersection light phases: NS green/yellow, all-red clearance, EW green/yellow, all-red clearance, optional pedestrian walk, plus emergency override.
- Contains its own prescaler, which generates a one-cycle tick enable every CLK_DIV cycles of Fin. The block does not produce a derived clock; all logic runs on Fin.
- Phase durations are in ticks. The block drives the lamp outputs and the countdown display directly.

Parameters:
- CLK_DIV, 10, Fin cycles per tick; legal range is 2 or more.
- T_GREEN, 8'd20, ticks per green phase (NS and EW).
- T_YELLOW, 8'd3, ticks per yellow phase.
- T_RED_CLR, 8'd1, ticks per all-red clearance phase.
- T_PED, 8'd10, ticks per pedestrian walk phase.
- All durations are 8-bit with legal range 1..255. A value of 0 is illegal and its behaviour is undefined.

Ports:
- Fin  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- ped_req  input  1  pedestrian button, synchronous to Fin; any-length pulse.
- emerg  input  1  emergency override level, synchronous to Fin.
- ns_light  output  3  NS lamps {R,Y,G}, one-hot.
- ew_light  output  3  EW lamps {R,Y,G}, one-hot.
- walk  output  1  pedestrian walk lamp.
- countdown  output  8  ticks remaining in the current phase.
- phase  output  3  current state code.

Behaviour:
- State codes: NS_GREEN=0, NS_YEL=1, ALL_RED1=2, EW_GREEN=3, EW_YEL=4, ALL_RED2=5, PED_WALK=6, EMERG=7.
- Lamps per state: NS_GREEN gives ns=001, ew=100. NS_YEL gives ns=010, ew=100. EW_GREEN gives ns=100, ew=001. EW_YEL gives ns=100, ew=010. ALL_RED1, ALL_RED2, PED_WALK and EMERG give ns=ew=100.
- walk=1 only in PED_WALK.
- All outputs are registered and update on the same edge as the state.
- Reset (asynchronous, takes effect immediately) sets:
  - state=ALL_RED2, phase=5, ns=ew=100, walk=0;
  - countdown=T_RED_CLR, prescaler=0, ped_pending=0.
- Prescaler:
  - Counts 0..CLK_DIV-1; tick=1 for exactly one cycle when the count equals CLK_DIV-1, then the count wraps to 0.
  - Forced to 0 on entry to and exit from EMERG, so each timed phase lasts exactly T_x*CLK_DIV cycles.
- Countdown, on a tick in a timed state:
  - if countdown>1, decrement;
  - if countdown==1, transition on that edge and load the next state's duration.
- Countdown is never observed at 0 except in EMERG, where it is held at 0.
- Transitions:
  - NS_GREEN to NS_YEL to ALL_RED1 to EW_GREEN to EW_YEL to ALL_RED2.
  - ALL_RED2 goes to PED_WALK if ped_pending, else to NS_GREEN.
  - PED_WALK goes to NS_GREEN.
- ped_pending:
  - Set in any cycle where ped_req=1 and state is not PED_WALK.
  - Cleared on the edge that enters PED_WALK; clear wins over a simultaneous set.
  - ped_req while in PED_WALK is ignored.
  - ped_pending survives EMERG.
- Emergency:
  - emerg=1 in any state, EMERG included, gives state EMERG on the next edge, with countdown=0 and prescaler=0.
  - The block stays in EMERG while emerg=1.
  - The first edge with emerg=0 while in EMERG gives ALL_RED2 with countdown=T_RED_CLR and prescaler=0.
  - emerg has priority over a phase transition on the same edge.
- No NS-green/EW-green overlap is reachable. Every green-to-green path passes through yellow and all-red, or through EMERG then all-red.

Test Plan:
Bench parameters: CLK_DIV=4, T_GREEN=3, T_YELLOW=2, T_RED_CLR=1, T_PED=2.
- Release rst, no inputs -> phase 5 for 4 cycles, then 0 for 12, 1 for 8, 2 for 4, 3 for 12, 4 for 8, 5 for 4, then back to 0. ns/ew lamps match the table in every cycle.
- Countdown in NS_GREEN -> 3 on entry, 2 after 4 cycles, 1 after 8, then phase=1 with countdown=2 after 12.
- 1-cycle ped_req during EW_GREEN -> after ALL_RED2, phase=6 with walk=1 and countdown=2 for 8 cycles, then phase=0 and walk=0. The next ALL_RED2 goes straight to NS_GREEN.
- emerg=1 at cycle 5 of NS_GREEN, held 10 cycles -> phase=7 on the next edge, all lamps 100, countdown=0. After deassert: phase=5 for 4 cycles, then phase=0.
- ped_req and emerg asserted in the same cycle -> EMERG is entered. After exit, ALL_RED2 leads to PED_WALK (pending retained).
- rst asserted mid EW_YEL, not aligned to an edge -> phase=5, ns=ew=100, walk=0, countdown=1 immediately. A ped_req latched before the reset is lost.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: intersection phase sequencer with built-in tick prescaler,
// pedestrian walk request latch and emergency all-red override.
module traffic_phase_ctrl #(
    parameter int         CLK_DIV   = 10,
    parameter logic [7:0] T_GREEN   = 8'd20,
    parameter logic [7:0] T_YELLOW  = 8'd3,
    parameter logic [7:0] T_RED_CLR = 8'd1,
    parameter logic [7:0] T_PED     = 8'd10
) (
    input  logic       Fin,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [7:0] countdown,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        NS_GREEN = 3'd0, NS_YEL = 3'd1, ALL_RED1 = 3'd2, EW_GREEN = 3'd3,
        EW_YEL = 3'd4, ALL_RED2 = 3'd5, PED_WALK = 3'd6, EMERG = 3'd7
    } state_t;

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    state_t        state, nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [7:0]    cd_nxt;
    logic          ped_pending, tick;

    function automatic logic [7:0] dur(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN: dur = T_GREEN;
            NS_YEL, EW_YEL:     dur = T_YELLOW;
            ALL_RED1, ALL_RED2: dur = T_RED_CLR;
            PED_WALK:           dur = T_PED;
            default:            dur = 8'd0;
        endcase
    endfunction

    function automatic state_t succ(input state_t s, input logic ped);
        case (s)
            NS_GREEN: succ = NS_YEL;
            NS_YEL:   succ = ALL_RED1;
            ALL_RED1: succ = EW_GREEN;
            EW_GREEN: succ = EW_YEL;
            EW_YEL:   succ = ALL_RED2;
            ALL_RED2: succ = ped ? PED_WALK : NS_GREEN;
            default:  succ = NS_GREEN;
        endcase
    endfunction

    // Entering or leaving EMERG restarts the prescaler so timed phases stay whole.
    always_comb begin
        tick      = presc == LAST;
        nxt       = state;
        cd_nxt    = countdown;
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (emerg) begin
            nxt       = EMERG;
            cd_nxt    = 8'd0;
            presc_nxt = '0;
        end else if (state == EMERG) begin
            nxt       = ALL_RED2;
            cd_nxt    = T_RED_CLR;
            presc_nxt = '0;
        end else if (tick) begin
            if (countdown > 8'd1) cd_nxt = countdown - 8'd1;
            else begin
                nxt    = succ(state, ped_pending);
                cd_nxt = dur(nxt);
            end
        end
    end

    always_ff @(posedge Fin or posedge rst) begin
        if (rst) begin
            state       <= ALL_RED2;
            presc       <= '0;
            countdown   <= T_RED_CLR;
            ped_pending <= 1'b0;
            ns_light    <= 3'b100;
            ew_light    <= 3'b100;
            walk        <= 1'b0;
        end else begin
            state       <= nxt;
            presc       <= presc_nxt;
            countdown   <= cd_nxt;
            ped_pending <= (nxt == PED_WALK && state != PED_WALK) ? 1'b0
                         : ped_pending | (ped_req && state != PED_WALK);
            ns_light    <= nxt == NS_GREEN ? 3'b001 : nxt == NS_YEL ? 3'b010 : 3'b100;
            ew_light    <= nxt == EW_GREEN ? 3'b001 : nxt == EW_YEL ? 3'b010 : 3'b100;
            walk        <= nxt == PED_WALK;
        end
    end

    assign phase = state;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: table-driven phase sequence check plus hand-written
// emergency, pedestrian and asynchronous reset sequences.
module tb_traffic_phase_ctrl;
    logic       Fin = 1'b0, rst = 1'b1, ped_req = 1'b0, emerg = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk;
    logic [7:0] countdown;
    int         checks = 0, failures = 0;

    traffic_phase_ctrl #(
        .CLK_DIV(4), .T_GREEN(8'd3), .T_YELLOW(8'd2), .T_RED_CLR(8'd1), .T_PED(8'd2)
    ) dut (
        .Fin(Fin), .rst(rst), .ped_req(ped_req), .emerg(emerg),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .countdown(countdown), .phase(phase)
    );

    always #5 Fin = ~Fin;

    // Each record spans one tick period (4 clocks); ped is pulsed on its first clock.
    typedef struct { logic ped; logic [2:0] ph; logic [7:0] cd; } vec_t;
    vec_t tbl [28];

    function automatic logic [5:0] lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    lamps = 6'b001_100;
            3'd1:    lamps = 6'b010_100;
            3'd3:    lamps = 6'b100_001;
            3'd4:    lamps = 6'b100_010;
            default: lamps = 6'b100_100;
        endcase
    endfunction

    task automatic check_state(input string name, input logic [2:0] ph, input logic [7:0] cd);
        logic [5:0] l;
        l = lamps(ph);
        checks++;
        if ({phase, countdown, ns_light, ew_light, walk} !== {ph, cd, l, ph == 3'd6}) begin
            failures++;
            $display("FAIL %s: got phase=%0d cd=%0d ns=%b ew=%b walk=%b, expected phase=%0d cd=%0d ns=%b ew=%b walk=%b",
                     name, phase, countdown, ns_light, ew_light, walk, ph, cd, l[5:3], l[2:0], ph == 3'd6);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Fin);
            #1;
        end
    endtask

    initial begin
        tbl = '{
            '{0, 3'd5, 8'd1}, '{0, 3'd0, 8'd3}, '{0, 3'd0, 8'd2}, '{0, 3'd0, 8'd1},
            '{0, 3'd1, 8'd2}, '{0, 3'd1, 8'd1}, '{0, 3'd2, 8'd1}, '{1, 3'd3, 8'd3},
            '{0, 3'd3, 8'd2}, '{0, 3'd3, 8'd1}, '{0, 3'd4, 8'd2}, '{0, 3'd4, 8'd1},
            '{0, 3'd5, 8'd1}, '{0, 3'd6, 8'd2}, '{0, 3'd6, 8'd1}, '{0, 3'd0, 8'd3},
            '{0, 3'd0, 8'd2}, '{0, 3'd0, 8'd1}, '{0, 3'd1, 8'd2}, '{0, 3'd1, 8'd1},
            '{0, 3'd2, 8'd1}, '{0, 3'd3, 8'd3}, '{0, 3'd3, 8'd2}, '{0, 3'd3, 8'd1},
            '{0, 3'd4, 8'd2}, '{0, 3'd4, 8'd1}, '{0, 3'd5, 8'd1}, '{0, 3'd0, 8'd3}
        };
        #12 rst = 1'b0;
        for (int i = 0; i < 28; i++)
            for (int j = 0; j < 4; j++) begin
                ped_req = tbl[i].ped && j == 0;
                check_state($sformatf("seq%0d_%0d", i, j), tbl[i].ph, tbl[i].cd);
                step(1);
            end
        ped_req = 1'b0;
        check_state("ns_green_c5", 3'd0, 8'd2);
        emerg = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check_state($sformatf("emerg_hold%0d", k), 3'd7, 8'd0);
        end
        emerg = 1'b0;
        step(1); check_state("emerg_exit", 3'd5, 8'd1);
        step(3); check_state("emerg_exit_red", 3'd5, 8'd1);
        step(1); check_state("emerg_to_ns", 3'd0, 8'd3);
        ped_req = 1'b1; emerg = 1'b1;
        step(1);
        ped_req = 1'b0;
        check_state("ped_emerg", 3'd7, 8'd0);
        emerg = 1'b0;
        step(1); check_state("ped_emerg_exit", 3'd5, 8'd1);
        step(4); check_state("ped_kept_walk", 3'd6, 8'd2);
        step(4); check_state("ped_kept_walk2", 3'd6, 8'd1);
        step(4); check_state("walk_to_ns", 3'd0, 8'd3);
        step(12); check_state("to_ns_yel", 3'd1, 8'd2);
        step(8); check_state("to_all_red1", 3'd2, 8'd1);
        step(4); check_state("to_ew_green", 3'd3, 8'd3);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(11); check_state("to_ew_yel", 3'd4, 8'd2);
        step(2);
        #3 rst = 1'b1;
        #1 check_state("rst_async", 3'd5, 8'd1);
        #10 rst = 1'b0;
        check_state("rst_release", 3'd5, 8'd1);
        step(3); check_state("rst_red", 3'd5, 8'd1);
        step(1); check_state("ped_lost", 3'd0, 8'd3);
        step(11); check_state("ns_before_tick", 3'd0, 8'd1);
        emerg = 1'b1;
        step(1); check_state("emerg_over_tick", 3'd7, 8'd0);
        emerg = 1'b0;
        step(1); check_state("emerg_over_tick_exit", 3'd5, 8'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
